bypass_scoreboard: RTL
======================

// Module: bypass_scoreboard
// PURPOSE
//  Parametrised operand-bypass and hazard unit for the ID stage. Tracks in-flight register
//  writes in a shadow pipeline of STAGES entries (entry 0 = EX, entry 1 = MEM, ...).
//  Forwards operands from the youngest producer and raises stall on load-use and busy-MDU hazards.
//  Resolves conditional branches from the forwarded operands.
//  Sits between the register file read and the ID/EX register.
// PARAMETERS
//  DATA_W     32  operand width
//  REG_AW     5   register address width; register 0 is hard zero
//  STAGES     3   in-flight entries tracked after ID (EX..WB), >=2
//  LOAD_STAGE 1   first entry index at which load data is valid on st_data
//  MDU_LAT    32  cycles HI/LO stays busy after an MDU op is issued, >=1
// PORTS
//  clk            in  1               clock, rising edge
//  resetn         in  1               synchronous reset, active-low
//  id_valid       in  1               ID holds a valid instruction
//  id_rs/id_rt    in  REG_AW          source register addresses
//  id_rs_used     in  1               instruction reads rs
//  id_rt_used     in  1               instruction reads rt
//  id_wen         in  1               instruction writes id_waddr
//  id_waddr       in  REG_AW          destination register
//  id_is_load     in  1               destination produced by memory read
//  id_is_mdu      in  1               mult/div issue (writes HI/LO)
//  id_reads_hilo  in  1               mfhi/mflo
//  flush          in  1               squash instruction in ID
//  rf_rdata1/2    in  DATA_W          register-file read data
//  st_data        in  STAGES*DATA_W   result of entry k at bits [k*DATA_W +: DATA_W]
//  br_op          in  3               0 none,1 BEQ,2 BNE,3 BGEZ,4 BGTZ,5 BLEZ,6 BLTZ
//  fwd_rdata1/2   out DATA_W          forwarded rs/rt operands
//  stall          out 1               hold PC/IF/ID, insert bubble into EX
//  br_taken       out 1               conditional branch taken
//  mdu_busy       out 1               HI/LO result pending
//  stall_cnt      out 32              saturating count of stall cycles
// BEHAVIOUR
//  Reset (resetn=0 at posedge): entries invalid, MDU counter=0, stall_cnt=0.
//   While resetn=0 the outputs are forced: stall=0, br_taken=0, fwd_rdata*=0.
//  Entry = {valid, waddr, is_load}.
//  Insert rule: entry 0 <= ID instruction when id_valid & id_wen & id_waddr!=0 & !stall & !flush.
//   Otherwise entry 0 <= bubble.
//  Shift rule: entry k <= entry k-1 every cycle; the last entry falls off.
//  Operand lookup, per source:
//   - Address 0 yields 0.
//   - Otherwise take the lowest-index valid entry with a matching waddr.
//   - Matching entry ready (not a load, or index >= LOAD_STAGE): forward its st_data slice.
//   - Matching entry not ready: hazard. No match: rf_rdata.
//  stall = id_valid & !flush & (rs hazard & id_rs_used | rt hazard & id_rt_used
//          | mdu_busy & (id_is_mdu | id_reads_hilo)).
//   stall is combinational from registered state and ID inputs.
//  MDU: on id_is_mdu & id_valid & !stall & !flush, counter <= MDU_LAT.
//   Else the counter decrements if nonzero, independent of stall. mdu_busy = counter!=0.
//  br_taken: evaluated on the forwarded operands, signed compare against 0 for op 3-6.
//   Forced to 0 when stall or flush. br_op 0 or 7 gives 0.
//  stall_cnt: +1 on each cycle with stall=1; holds at 32'hFFFF_FFFF.
//  flush has priority over stall: no stall, no insert, no MDU start that cycle.
//  Back-to-back writers to the same register: the youngest wins.
//   Writes to reg 0 are never tracked.
// TESTING
//  1. Reset: entries invalid, stall=0, stall_cnt=0.
//   Then ID writes r3; next cycle ID reads r3 with st_data[0]=32'h1234 -> fwd_rdata1=32'h1234, stall=0.
//  2. Load to r5, then a reader of r5 next cycle -> stall=1 for 1 cycle (LOAD_STAGE=1).
//   Then fwd_rdata1=st_data[1]; stall_cnt=1.
//  3. ID writes r7=A, then again r7=B; a reader one cycle later -> gets entry 0 data B, not entry 1 data A.
//  4. mult issued, mfhi next cycle -> stall held MDU_LAT cycles (32).
//   Then released; stall_cnt=32. A flush during the stall drops stall the same cycle.
//  5. BGEZ, rs forwarded = 32'h8000_0000 -> br_taken=0.
//   BNE, rs=5, rt=4 via rf -> br_taken=1. BEQ with a pending load hazard -> br_taken=0, stall=1.
//  6. resetn=0 for 1 cycle mid-stall -> stall=0 during reset, all entries cleared, mdu_busy=0 after.

Source files
------------

// File: rtl/bypass_scoreboard.sv
// ID-stage operand bypass and hazard unit: tracks in-flight writers, forwards the youngest
// ready producer, stalls on load-use and busy HI/LO, and resolves conditional branches.
module bypass_scoreboard #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned STAGES     = 3,
   parameter int unsigned LOAD_STAGE = 1,
   parameter int unsigned MDU_LAT    = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     id_valid,
   input  logic [REG_AW-1:0]        id_rs,
   input  logic [REG_AW-1:0]        id_rt,
   input  logic                     id_rs_used,
   input  logic                     id_rt_used,
   input  logic                     id_wen,
   input  logic [REG_AW-1:0]        id_waddr,
   input  logic                     id_is_load,
   input  logic                     id_is_mdu,
   input  logic                     id_reads_hilo,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        rf_rdata1,
   input  logic [DATA_W-1:0]        rf_rdata2,
   input  logic [STAGES*DATA_W-1:0] st_data,
   input  logic [2:0]               br_op,
   output logic [DATA_W-1:0]        fwd_rdata1,
   output logic [DATA_W-1:0]        fwd_rdata2,
   output logic                     stall,
   output logic                     br_taken,
   output logic                     mdu_busy,
   output logic [31:0]              stall_cnt
);

   localparam int unsigned CntW = $clog2(MDU_LAT + 1);

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] load_q;
   logic [REG_AW-1:0] waddr_q [STAGES];
   logic [CntW-1:0]   mdu_cnt_q;
   logic [31:0]       stall_cnt_q;

   logic              rs_haz, rt_haz, stall_int, taken_raw, insert;
   logic [DATA_W-1:0] rs_val, rt_val;

   // Returns {hazard, data}; scanning oldest-to-youngest lets the youngest match win.
   function automatic logic [DATA_W:0] lookup(input logic [REG_AW-1:0] addr,
                                              input logic [DATA_W-1:0] rf);
      logic [DATA_W:0] res;
      res = {1'b0, rf};
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         if (valid_q[k] && waddr_q[k] == addr) begin
            if (load_q[k] && k < int'(LOAD_STAGE)) res = {1'b1, rf};
            else                                   res = {1'b0, st_data[k*DATA_W +: DATA_W]};
         end
      end
      if (addr == '0) res = '0;
      return res;
   endfunction

   always_comb begin
      {rs_haz, rs_val} = lookup(id_rs, rf_rdata1);
      {rt_haz, rt_val} = lookup(id_rt, rf_rdata2);
      mdu_busy  = (mdu_cnt_q != '0);
      stall_int = id_valid & ~flush & ((rs_haz & id_rs_used) | (rt_haz & id_rt_used) |
                                       (mdu_busy & (id_is_mdu | id_reads_hilo)));
      insert    = id_valid & id_wen & (id_waddr != '0) & ~stall_int & ~flush;

      taken_raw = 1'b0;
      case (br_op)
         3'd1:    taken_raw = (rs_val == rt_val);
         3'd2:    taken_raw = (rs_val != rt_val);
         3'd3:    taken_raw = ~rs_val[DATA_W-1];
         3'd4:    taken_raw = ~rs_val[DATA_W-1] & (rs_val != '0);
         3'd5:    taken_raw = rs_val[DATA_W-1] | (rs_val == '0);
         3'd6:    taken_raw = rs_val[DATA_W-1];
         default: taken_raw = 1'b0;
      endcase

      stall      = resetn & stall_int;
      br_taken   = resetn & ~stall_int & ~flush & taken_raw;
      fwd_rdata1 = resetn ? rs_val : '0;
      fwd_rdata2 = resetn ? rt_val : '0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q     <= '0;
         load_q      <= '0;
         mdu_cnt_q   <= '0;
         stall_cnt_q <= '0;
         for (int k = 0; k < int'(STAGES); k++) waddr_q[k] <= '0;
      end else begin
         valid_q    <= {valid_q[STAGES-2:0], insert};
         load_q     <= {load_q[STAGES-2:0], id_is_load & insert};
         waddr_q[0] <= id_waddr;
         for (int k = 1; k < int'(STAGES); k++) waddr_q[k] <= waddr_q[k-1];

         if (id_valid && id_is_mdu && !stall_int && !flush) mdu_cnt_q <= CntW'(MDU_LAT);
         else if (mdu_cnt_q != '0)                          mdu_cnt_q <= mdu_cnt_q - 1'b1;

         if (stall_int && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule
